uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one UART transmit line among NUM_REQ byte sources. Round-robin arbitration picks one source.
//  The block then serialises 8N1/8N2 frames, with bit timing taken from the TX baud square wave of the
//  baud rate generator. It sits between the generator (o_Tx_ClkTick -> i_Tx_BaudClk) and the pad.
// PARAMETERS
//  NUM_REQ    4  number of requesters, >=2
//  DATA_BITS  8  data bits per frame, LSB first
//  STOP_BITS  1  stop bits per frame, 1 or 2
// PORTS
//  clk           in   1                  system clock; single clock domain
//  reset_n       in   1                  asynchronous, active-low reset
//  i_Tx_BaudClk  in   1                  baud square wave, one full period per bit, synchronous to clk
//  i_Req_Valid   in   NUM_REQ            per-requester byte valid
//  i_Req_Data    in   NUM_REQ*DATA_BITS  requester k data in slice [k*DATA_BITS +: DATA_BITS]
//  o_Req_Ready   out  NUM_REQ            one-hot accept pulse; transfer = valid & ready
//  o_Grant_Id    out  $clog2(NUM_REQ)    index of the requester currently being sent
//  o_Tx_Busy     out  1                  high from grant until the frame completes
//  o_Tx_Serial   out  1                  UART line, idle high
//  o_Frame_Done  out  1                  1-cycle pulse at the end of the last stop bit
// BEHAVIOUR
//  Reset values: o_Tx_Serial=1; o_Req_Ready=0; o_Grant_Id=0; o_Tx_Busy=0; o_Frame_Done=0;
//   state=IDLE; last-grant pointer=NUM_REQ-1, so requester 0 has first priority.
//  Baud edge: register i_Tx_BaudClk (reset 0). baud_edge = i_Tx_BaudClk & ~q, a 1-cycle pulse on each
//   rising edge. Every line transition happens on the clk cycle following baud_edge.
//  FSM states IDLE, SYNC, START, DATA, STOP:
//   IDLE : if any i_Req_Valid, grant the first valid index after the last grant, wrapping modulo NUM_REQ.
//          Same cycle: latch that data slice, pulse o_Req_Ready[k], set o_Grant_Id=k, o_Tx_Busy=1,
//          update last-grant to k, go to SYNC. One grant per cycle at most; no valid -> stay in IDLE.
//   SYNC : wait for baud_edge. On the edge drive o_Tx_Serial=0 and go to START.
//   START: on baud_edge drive data[0], clear bit_cnt, go to DATA.
//   DATA : on baud_edge, if bit_cnt==DATA_BITS-1 drive 1, clear stop_cnt, go to STOP;
//          otherwise bit_cnt++ and drive data[bit_cnt+1].
//   STOP : on baud_edge, if stop_cnt==STOP_BITS-1 pulse o_Frame_Done, drop o_Tx_Busy, go to IDLE;
//          otherwise stop_cnt++.
//  Bit period: every bit lasts exactly one baud period. If a baud edge coincides with the grant cycle it
//   is not consumed; the start bit waits for the next edge.
//  Back-to-back frames: the next grant occurs one cycle after o_Frame_Done and the start bit begins at the
//   following edge. The line therefore idles one extra bit time, deterministically.
//  Handshake: a requester must hold valid and data stable until it sees ready. Valid dropped before grant
//   means no transfer. Valid changes during a frame have no effect. A non-granted requester is never
//   starved: with all valid, the grant order is 0,1,..,NUM_REQ-1,0.
//  Widths: bit_cnt is $clog2(DATA_BITS) wide; stop_cnt is 1 bit. The data shift register is DATA_BITS wide.
//  Reset asserted mid-frame: the line returns high immediately, the frame is abandoned and no
//   o_Frame_Done is issued. After release, arbitration restarts with requester 0 having first priority.
//  No combinational path from inputs to outputs. All outputs are registered.
// STRUCTURE
//  uart_pkg: typedef enum logic [2:0] {IDLE,SYNC,START,DATA,STOP} uart_tx_state_t; constants
//   UART_IDLE_LVL=1'b1 and UART_START_LVL=1'b0. The arbiter and serializer both import it.
//  Sub-module uart_rr_arbiter #(NUM_REQ): inputs req, enable, last_grant; outputs one-hot grant and
//   grant_idx. Purely combinational; the pointer register stays in the top module.
//  Top module: baud edge detector, FSM, shift register, counters, output registers.
// TESTING
//  Clock the DUT from a real baudRateGenerator at CLOCK_RATE=25e6, BAUD_RATE=115200, so one bit is about
//   217 clocks. A UART monitor samples mid-bit.
//  1 Reset then valid[2]=1, data2=0xA5: ready[2] pulses once. The line carries 0,1,0,1,0,0,1,0,1,1, one bit
//    per baud period. o_Grant_Id=2 for the whole frame; o_Frame_Done pulses once at the end.
//  2 All four valid, data k=0x10+k, held until each ready: frames go out in order 0x10,0x11,0x12,0x13.
//    Each gap is exactly one idle bit. Re-raising valid[0] afterwards sends 0x10 again.
//  3 Last grant=1, valid on 0 and 3: requester 3 is sent first, then 0 (wrap-around).
//  4 STOP_BITS=2 build, data 0xFF: stop high for 2 bit periods before o_Frame_Done pulses; busy spans
//    11 bit periods.
//  5 reset_n low during DATA bit 4: o_Tx_Serial=1 and busy=0 within the reset. No o_Frame_Done. After
//    release, valid[1] and valid[0] both high: requester 0 is granted first.
//  6 valid[3] pulsed for 1 cycle during a frame, then dropped: no ready[3] and no frame for requester 3.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//  Shared types and line levels for the UART transmit scheduler.
//  Contents:
//   uart_tx_state_t  transmitter FSM state (IDLE, SYNC, START, DATA, STOP)
//   UART_IDLE_LVL    line level when idle and during stop bits
//   UART_START_LVL   line level of the start bit
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SYNC  = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } uart_tx_state_t;

   localparam logic UART_IDLE_LVL  = 1'b1;
   localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/uart_rr_arbiter.sv
// -----------------------------------------------------------------------------
// uart_rr_arbiter
//  Combinational round-robin pick. Searches from the requester just after
//  last_grant, wrapping modulo NUM_REQ, and returns the first one requesting.
//  The last-grant pointer register lives in the parent.
//  Ports:
//   req        in   NUM_REQ          request vector
//   enable     in   1                allow a grant this cycle
//   last_grant in   $clog2(NUM_REQ)  index granted most recently
//   grant      out  NUM_REQ          one-hot grant (all zero if none)
//   grant_idx  out  $clog2(NUM_REQ)  index of the granted requester
// -----------------------------------------------------------------------------
module uart_rr_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       enable,
   input  logic [$clog2(NUM_REQ)-1:0] last_grant,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

   localparam int IDX_W = $clog2(NUM_REQ);

   always_comb begin
      int               idx;
      logic [IDX_W-1:0] k;
      logic             found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      k         = '0;
      // Distance 1 first so the previous winner has the lowest priority.
      for (int o = 1; o <= NUM_REQ; o++) begin
         idx = (int'(last_grant) + o) % NUM_REQ;
         k   = IDX_W'(idx);
         if (enable && !found && req[k]) begin
            found     = 1'b1;
            grant_idx = k;
         end
      end
      if (found) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//  Shares one UART TX line among NUM_REQ byte sources. A round-robin arbiter
//  picks a source in IDLE, then the byte is sent as a start bit, DATA_BITS
//  data bits (LSB first) and STOP_BITS stop bits. Bit timing comes from the
//  rising edges of the baud square wave; every line change happens on the clk
//  cycle after a detected baud edge. All outputs are registered.
//  Ports:
//   clk, reset_n   clock, async active-low reset
//   i_Tx_BaudClk   baud square wave, one period per bit, synchronous to clk
//   i_Req_Valid    per-requester valid
//   i_Req_Data     requester k data at [k*DATA_BITS +: DATA_BITS]
//   o_Req_Ready    one-hot accept pulse (transfer = valid & ready)
//   o_Grant_Id     index of requester being sent
//   o_Tx_Busy      high from grant until the frame completes
//   o_Tx_Serial    UART line, idle high
//   o_Frame_Done   1-cycle pulse at the end of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           i_Tx_BaudClk,
   input  logic [NUM_REQ-1:0]             i_Req_Valid,
   input  logic [NUM_REQ*DATA_BITS-1:0]   i_Req_Data,
   output logic [NUM_REQ-1:0]             o_Req_Ready,
   output logic [$clog2(NUM_REQ)-1:0]     o_Grant_Id,
   output logic                           o_Tx_Busy,
   output logic                           o_Tx_Serial,
   output logic                           o_Frame_Done
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   uart_tx_state_t                         state, state_nxt;
   logic                                   baud_q, baud_edge;
   logic [IDX_W-1:0]                       last_grant, last_d;
   logic [NUM_REQ-1:0]                     arb_grant;
   logic [IDX_W-1:0]                       arb_idx;
   logic [NUM_REQ-1:0][DATA_BITS-1:0]      req_data;
   logic [DATA_BITS-1:0]                   shreg, shreg_d;
   logic [CNT_W-1:0]                       bit_cnt, bit_cnt_d;
   logic                                   stop_cnt, stop_cnt_d;
   logic                                   serial_d, busy_d, done_d;
   logic [NUM_REQ-1:0]                     ready_d;
   logic [IDX_W-1:0]                       gid_d;
   logic                                   last_bit, last_stop;

   assign req_data  = i_Req_Data;
   assign baud_edge = i_Tx_BaudClk & ~baud_q;
   assign last_bit  = (bit_cnt == CNT_W'(DATA_BITS-1));
   assign last_stop = (stop_cnt == 1'(STOP_BITS-1));

   uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req        (i_Req_Valid),
      .enable     (state == IDLE),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .grant_idx  (arb_idx)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state. A baud edge seen in IDLE (the grant cycle) is ignored, so the
   // start bit always waits for a fresh edge and lasts a full period.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (|arb_grant)             state_nxt = SYNC;
         SYNC:  if (baud_edge)              state_nxt = START;
         START: if (baud_edge)              state_nxt = DATA;
         DATA:  if (baud_edge && last_bit)  state_nxt = STOP;
         STOP:  if (baud_edge && last_stop) state_nxt = IDLE;
         default:                           state_nxt = IDLE;
      endcase
   end

   // Next values of the datapath and output registers
   always_comb begin
      serial_d   = o_Tx_Serial;
      ready_d    = '0;
      gid_d      = o_Grant_Id;
      busy_d     = o_Tx_Busy;
      done_d     = 1'b0;
      shreg_d    = shreg;
      bit_cnt_d  = bit_cnt;
      stop_cnt_d = stop_cnt;
      last_d     = last_grant;
      case (state)
         IDLE: begin
            if (|arb_grant) begin
               ready_d = arb_grant;
               gid_d   = arb_idx;
               busy_d  = 1'b1;
               last_d  = arb_idx;
               shreg_d = req_data[arb_idx];
            end
         end
         SYNC: begin
            if (baud_edge) serial_d = UART_START_LVL;
         end
         START: begin
            if (baud_edge) begin
               serial_d  = shreg[0];
               shreg_d   = shreg >> 1;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (baud_edge) begin
               if (last_bit) begin
                  serial_d   = UART_IDLE_LVL;
                  stop_cnt_d = 1'b0;
               end else begin
                  // shreg[0] already holds data[bit_cnt+1]
                  serial_d  = shreg[0];
                  shreg_d   = shreg >> 1;
                  bit_cnt_d = bit_cnt + CNT_W'(1);
               end
            end
         end
         STOP: begin
            if (baud_edge) begin
               if (last_stop) begin
                  done_d = 1'b1;
                  busy_d = 1'b0;
               end else begin
                  stop_cnt_d = stop_cnt + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         baud_q       <= 1'b0;
         o_Tx_Serial  <= UART_IDLE_LVL;
         o_Req_Ready  <= '0;
         o_Grant_Id   <= '0;
         o_Tx_Busy    <= 1'b0;
         o_Frame_Done <= 1'b0;
         shreg        <= '0;
         bit_cnt      <= '0;
         stop_cnt     <= 1'b0;
         last_grant   <= IDX_W'(NUM_REQ-1);
      end else begin
         baud_q       <= i_Tx_BaudClk;
         o_Tx_Serial  <= serial_d;
         o_Req_Ready  <= ready_d;
         o_Grant_Id   <= gid_d;
         o_Tx_Busy    <= busy_d;
         o_Frame_Done <= done_d;
         shreg        <= shreg_d;
         bit_cnt      <= bit_cnt_d;
         stop_cnt     <= stop_cnt_d;
         last_grant   <= last_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//  Two DUTs share clock, reset and baud wave: dut (8N1) and dut2 (8N2).
//  The baud wave is a 25 MHz / 115200 divider. A mid-bit sampling receiver
//  decodes frames; a round-robin order model predicts grant order and data.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int DIV   = 25_000_000 / 115_200;
   localparam int BOUND = 30 * DIV;

   logic              clk = 1'b0, reset_n = 1'b0, baud = 1'b0;
   int                bcnt = 0;
   logic [N-1:0]      valid = '0, valid2 = '0;
   logic [N*DW-1:0]   data = '0, data2 = '0;
   logic [N-1:0]      ready, ready2;
   logic [1:0]        gid, gid2;
   logic              busy, busy2, ser, ser2, done, done2;

   int vec = 0, miss = 0, cyc = 0;
   int done_cnt = 0, done2_cnt = 0, spur = 0;
   int rdy_cnt [N];
   int glog [$];
   int m_last = N-1;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      bcnt <= (bcnt == DIV-1) ? 0 : bcnt + 1;
      baud <= (bcnt < DIV/2);
   end

   uart_tx_scheduler #(.NUM_REQ(N), .DATA_BITS(DW), .STOP_BITS(1)) dut (
      .clk(clk), .reset_n(reset_n), .i_Tx_BaudClk(baud),
      .i_Req_Valid(valid), .i_Req_Data(data), .o_Req_Ready(ready),
      .o_Grant_Id(gid), .o_Tx_Busy(busy), .o_Tx_Serial(ser), .o_Frame_Done(done)
   );

   uart_tx_scheduler #(.NUM_REQ(N), .DATA_BITS(DW), .STOP_BITS(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .i_Tx_BaudClk(baud),
      .i_Req_Valid(valid2), .i_Req_Data(data2), .o_Req_Ready(ready2),
      .o_Grant_Id(gid2), .o_Tx_Busy(busy2), .o_Tx_Serial(ser2), .o_Frame_Done(done2)
   );

   function automatic logic ln(input bit two);
      return two ? ser2 : ser;
   endfunction

   // One clock at the negedge: count pulses, act as requesters (drop valid on ready)
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (done)  done_cnt++;
      if (done2) done2_cnt++;
      if (!$onehot0(ready)) spur++;
      for (int k = 0; k < N; k++) begin
         if (ready[k]) begin
            if (!valid[k]) spur++;
            else begin rdy_cnt[k]++; glog.push_back(k); valid[k] = 1'b0; end
         end
         if (ready2[k]) begin
            if (!valid2[k]) spur++;
            valid2[k] = 1'b0;
         end
      end
   endtask

   task automatic wait_fall(input bit two, output bit found);
      logic prev;
      found = 1'b0;
      prev  = ln(two);
      for (int n = 0; n < BOUND && !found; n++) begin
         tick();
         if (prev && !ln(two)) found = 1'b1;
         prev = ln(two);
      end
   endtask

   // Receive one frame, sampling mid-bit; ok clears on bad start/stop, busy low
   // or grant id changing during the frame.
   task automatic rx_frame(input bit two, input int stops, output logic [7:0] d,
                           output int t0, output int g, output bit ok);
      bit found;
      d = '0; t0 = -1; g = -1; ok = 1'b0;
      wait_fall(two, found);
      if (!found) return;
      t0 = cyc; ok = 1'b1;
      repeat (DIV/2) tick();
      if (ln(two) !== 1'b0) ok = 1'b0;
      g = two ? int'(gid2) : int'(gid);
      for (int i = 0; i < DW; i++) begin
         repeat (DIV) tick();
         d[i] = ln(two);
         if ((two ? int'(gid2) : int'(gid)) != g || !(two ? busy2 : busy)) ok = 1'b0;
      end
      for (int s = 0; s < stops; s++) begin
         repeat (DIV) tick();
         if (ln(two) !== 1'b1 || !(two ? busy2 : busy)) ok = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy || busy2) && n < BOUND) begin tick(); n++; end
      vec++;
      if (busy || busy2) begin
         miss++;
         $display("FAIL %s idle-timeout: busy=%0d busy2=%0d after %0d cycles, want 0", name, busy, busy2, n);
      end
   endtask

   // Raise valid on every requester in mask; expect frames in round-robin order.
   task automatic run_batch(input string name, input logic [N-1:0] mask, input logic [N*DW-1:0] din);
      int exp_q [$];
      int dn0, prev_t0, t0, g;
      logic [7:0] d, want;
      bit ok, same;
      glog.delete();
      dn0 = done_cnt;
      for (int k = 0; k < N; k++)
         if (mask[k]) begin data[k*DW +: DW] = din[k*DW +: DW]; valid[k] = 1'b1; end
      for (int o = 1; o <= N; o++) begin
         int k = (m_last + o) % N;
         if (mask[k]) exp_q.push_back(k);
      end
      prev_t0 = -1;
      foreach (exp_q[i]) begin
         rx_frame(1'b0, 1, d, t0, g, ok);
         want = din[exp_q[i]*DW +: DW];
         vec++;
         if (!ok || d !== want || g != exp_q[i]) begin
            miss++;
            $display("FAIL %s frame%0d: got data=%02h id=%0d ok=%0d, want data=%02h id=%0d ok=1",
                     name, i, d, g, ok, want, exp_q[i]);
         end
         if (i > 0) begin
            vec++;
            if (t0 - prev_t0 != 11*DIV) begin
               miss++;
               $display("FAIL %s gap%0d: got %0d cycles start-to-start, want %0d", name, i, t0 - prev_t0, 11*DIV);
            end
         end
         prev_t0 = t0;
      end
      wait_idle(name);
      same = (glog.size() == exp_q.size());
      foreach (exp_q[i]) if (same && glog[i] != exp_q[i]) same = 1'b0;
      vec++;
      if (!same || done_cnt - dn0 != exp_q.size()) begin
         miss++;
         $display("FAIL %s order: got %0d grants, %0d done pulses, want %0d of each in rr order",
                  name, glog.size(), done_cnt - dn0, exp_q.size());
      end
      m_last = exp_q[exp_q.size()-1];
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      vec++;
      if ({ser, ready, gid, busy, done} !== 9'b1_0000_00_0_0 || ser2 !== 1'b1 || busy2 !== 1'b0) begin
         miss++;
         $display("FAIL reset: got ser=%b ready=%b gid=%0d busy=%b done=%b, want 1 0000 0 0 0",
                  ser, ready, gid, busy, done);
      end
      reset_n = 1'b1;
      m_last  = N-1;
      repeat (2) tick();
   endtask

   task automatic test_single();
      logic [N*DW-1:0] din = '0;
      int r0 = rdy_cnt[2];
      din[2*DW +: DW] = 8'hA5;
      run_batch("single", 4'b0100, din);
      vec++;
      if (rdy_cnt[2] - r0 != 1) begin
         miss++;
         $display("FAIL single ready2: got %0d pulses, want 1", rdy_cnt[2] - r0);
      end
   endtask

   task automatic test_all_valid();
      logic [N*DW-1:0] din;
      for (int k = 0; k < N; k++) din[k*DW +: DW] = 8'(8'h10 + k);
      run_batch("all_valid", 4'b1111, din);
      run_batch("revalid0", 4'b0001, din);
   endtask

   task automatic test_wrap();
      logic [N*DW-1:0] din;
      for (int k = 0; k < N; k++) din[k*DW +: DW] = 8'($urandom);
      run_batch("wrap_setup", 4'b0010, din);
      run_batch("wrap", 4'b1001, din);
      vec++;
      if (glog.size() != 2 || glog[0] != 3 || glog[1] != 0) begin
         miss++;
         $display("FAIL wrap order: got %0d grants first=%0d, want 3 then 0", glog.size(),
                  glog.size() > 0 ? glog[0] : -1);
      end
   endtask

   task automatic test_stop2();
      logic [7:0] d;
      int t0, g, d0, n;
      bit ok;
      d0 = done2_cnt;
      data2[1*DW +: DW] = 8'hFF;
      valid2[1] = 1'b1;
      rx_frame(1'b1, 2, d, t0, g, ok);
      vec++;
      if (!ok || d !== 8'hFF || g != 1) begin
         miss++;
         $display("FAIL stop2 frame: got data=%02h id=%0d ok=%0d, want FF 1 1", d, g, ok);
      end
      n = 0;
      while (done2_cnt == d0 && n < BOUND) begin tick(); n++; end
      vec++;
      if (done2_cnt - d0 != 1 || cyc - t0 != 11*DIV || busy2 !== 1'b0) begin
         miss++;
         $display("FAIL stop2 timing: got done=%0d at %0d cycles busy2=%b, want 1 at %0d busy2=0",
                  done2_cnt - d0, cyc - t0, busy2, 11*DIV);
      end
      wait_idle("stop2");
   endtask

   task automatic test_reset_midframe();
      bit found;
      int d0;
      logic [N*DW-1:0] din;
      data[2*DW +: DW] = 8'($urandom);
      valid[2] = 1'b1;
      wait_fall(1'b0, found);
      repeat (DIV/2 + 5*DIV) tick();
      d0 = done_cnt;
      reset_n = 1'b0;
      #1;
      vec++;
      if (!found || ser !== 1'b1 || busy !== 1'b0) begin
         miss++;
         $display("FAIL reset_mid: got started=%0d ser=%b busy=%b, want 1 1 0", found, ser, busy);
      end
      repeat (3) tick();
      reset_n = 1'b1;
      m_last  = N-1;
      repeat (DIV) tick();
      vec++;
      if (done_cnt != d0 || ser !== 1'b1) begin
         miss++;
         $display("FAIL reset_mid done: got %0d done pulses ser=%b, want 0 ser=1", done_cnt - d0, ser);
      end
      for (int k = 0; k < N; k++) din[k*DW +: DW] = 8'($urandom);
      run_batch("after_reset", 4'b0011, din);
   endtask

   task automatic test_valid_glitch();
      bit found;
      int r3, low_seen;
      r3 = rdy_cnt[3];
      glog.delete();
      data[2*DW +: DW] = 8'($urandom);
      valid[2] = 1'b1;
      wait_fall(1'b0, found);
      repeat (3*DIV) tick();
      data[3*DW +: DW] = 8'($urandom);
      valid[3] = 1'b1;
      tick();
      valid[3] = 1'b0;
      wait_idle("glitch");
      m_last = 2;
      low_seen = 0;
      for (int i = 0; i < 3*DIV; i++) begin
         tick();
         if (ser !== 1'b1 || busy !== 1'b0) low_seen++;
      end
      vec++;
      if (!found || rdy_cnt[3] != r3 || low_seen != 0 || glog.size() != 1) begin
         miss++;
         $display("FAIL glitch: got ready3=%0d grants=%0d active_cycles=%0d, want 0 1 0",
                  rdy_cnt[3] - r3, glog.size(), low_seen);
      end
   endtask

   task automatic test_random();
      logic [N*DW-1:0] din;
      logic [N-1:0] mask;
      for (int r = 0; r < 2; r++) begin
         mask = 4'($urandom_range(1, 15));
         for (int k = 0; k < N; k++) din[k*DW +: DW] = 8'($urandom);
         run_batch("random", mask, din);
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) rdy_cnt[k] = 0;
      test_reset();
      test_single();
      test_all_valid();
      test_wrap();
      test_stop2();
      test_reset_midframe();
      test_valid_glitch();
      test_random();
      vec++;
      if (spur != 0) begin
         miss++;
         $display("FAIL ready_protocol: got %0d ready pulses without valid or not one-hot, want 0", spur);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
